hazard_stall_ctrl: RTL

//  Stall/bubble controller for the 5-stage MIPS pipeline. It drives the hold of PC and IF/ID,
//  and the clear input of the ID/EX register.

---
 rtl/hazard_stall_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// Stall/bubble controller for the 5-stage MIPS pipeline: compares the ID instruction's Tuse
// against shadow EX/MEM Tnew records and tracks the multi-cycle mult/div unit.
module hazard_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] id_instr,
  output logic        stall,
  output logic        flush_idex,
  output logic        md_busy
);

  if (MULT_CYCLES > 15) begin : g_mult_cycles_range
    $error("MULT_CYCLES must fit the 4-bit busy counter (<= 15)");
  end
  if (DIV_CYCLES > 15) begin : g_div_cycles_range
    $error("DIV_CYCLES must fit the 4-bit busy counter (<= 15)");
  end

  localparam logic [3:0] MultLoad = 4'(MULT_CYCLES);
  localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpOri   = 6'h0d;
  localparam logic [5:0] OpLui   = 6'h0f;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  localparam logic [5:0] FnJr    = 6'h08;
  localparam logic [5:0] FnMfhi  = 6'h10;
  localparam logic [5:0] FnMthi  = 6'h11;
  localparam logic [5:0] FnMflo  = 6'h12;
  localparam logic [5:0] FnMtlo  = 6'h13;
  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19;
  localparam logic [5:0] FnDiv   = 6'h1a;
  localparam logic [5:0] FnDivu  = 6'h1b;
  localparam logic [5:0] FnAddu  = 6'h21;
  localparam logic [5:0] FnSubu  = 6'h23;

  // Instruction fields
  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic [4:0] w_rd;
  logic       w_unused_shamt;

  assign w_op           = id_instr[31:26];
  assign w_rs           = id_instr[25:21];
  assign w_rt           = id_instr[20:16];
  assign w_rd           = id_instr[15:11];
  assign w_funct        = id_instr[5:0];
  assign w_unused_shamt = ^id_instr[10:6];

  // Instruction class decode
  logic w_rtype;
  logic w_addu, w_subu, w_jr;
  logic w_mult, w_div;
  logic w_mfhi, w_mflo, w_mthi, w_mtlo;
  logic w_ori, w_lui, w_lw, w_sw, w_beq, w_jal, w_j;
  logic w_md_op;

  assign w_rtype = (w_op == OpRtype);
  assign w_addu  = w_rtype && (w_funct == FnAddu);
  assign w_subu  = w_rtype && (w_funct == FnSubu);
  assign w_jr    = w_rtype && (w_funct == FnJr);
  assign w_mult  = w_rtype && ((w_funct == FnMult) || (w_funct == FnMultu));
  assign w_div   = w_rtype && ((w_funct == FnDiv) || (w_funct == FnDivu));
  assign w_mfhi  = w_rtype && (w_funct == FnMfhi);
  assign w_mflo  = w_rtype && (w_funct == FnMflo);
  assign w_mthi  = w_rtype && (w_funct == FnMthi);
  assign w_mtlo  = w_rtype && (w_funct == FnMtlo);
  assign w_ori   = (w_op == OpOri);
  assign w_lui   = (w_op == OpLui);
  assign w_lw    = (w_op == OpLw);
  assign w_sw    = (w_op == OpSw);
  assign w_beq   = (w_op == OpBeq);
  assign w_jal   = (w_op == OpJal);
  assign w_j     = (w_op == OpJ);
  assign w_md_op = w_mult || w_div || w_mfhi || w_mflo || w_mthi || w_mtlo;

  // Tuse per source operand and dst/Tnew at EX entry
  logic       w_rs_used;
  logic [1:0] w_rs_tuse;
  logic       w_rt_used;
  logic [1:0] w_rt_tuse;
  logic [4:0] w_dst;
  logic [1:0] w_tnew;

  always_comb begin
    w_rs_used = 1'b0;
    w_rs_tuse = 2'd0;
    if (w_beq || w_jr) begin
      w_rs_used = 1'b1;
      w_rs_tuse = 2'd0;
    end else if (w_addu || w_subu || w_ori || w_lw || w_sw || w_mult || w_div || w_mthi ||
                 w_mtlo) begin
      w_rs_used = 1'b1;
      w_rs_tuse = 2'd1;
    end
  end

  always_comb begin
    w_rt_used = 1'b0;
    w_rt_tuse = 2'd0;
    if (w_beq) begin
      w_rt_used = 1'b1;
      w_rt_tuse = 2'd0;
    end else if (w_addu || w_subu || w_mult || w_div) begin
      w_rt_used = 1'b1;
      w_rt_tuse = 2'd1;
    end else if (w_sw) begin
      w_rt_used = 1'b1;
      w_rt_tuse = 2'd2;
    end
  end

  // j produces nothing; it is listed only so it is not mistaken for an unsupported opcode
  always_comb begin
    w_dst  = 5'd0;
    w_tnew = 2'd0;
    if (w_addu || w_subu || w_mfhi || w_mflo) begin
      w_dst  = w_rd;
      w_tnew = 2'd1;
    end else if (w_ori || w_lui) begin
      w_dst  = w_rt;
      w_tnew = 2'd1;
    end else if (w_lw) begin
      w_dst  = w_rt;
      w_tnew = 2'd2;
    end else if (w_jal) begin
      w_dst  = 5'd31;
      w_tnew = 2'd0;
    end else if (w_j) begin
      w_dst  = 5'd0;
      w_tnew = 2'd0;
    end
  end

  // Shadow pipeline state
  logic [4:0] r_e_dst;
  logic [1:0] r_e_tnew;
  logic       r_e_md;
  logic       r_e_div;
  logic [4:0] r_m_dst;
  logic [1:0] r_m_tnew;
  logic [3:0] r_md_cnt;

  // Hazard detection
  logic w_rs_hazard;
  logic w_rt_hazard;
  logic w_md_hazard;

  assign w_rs_hazard = w_rs_used && (w_rs != 5'd0) &&
                       (((r_e_dst == w_rs) && (r_e_tnew > w_rs_tuse)) ||
                        ((r_m_dst == w_rs) && (r_m_tnew > w_rs_tuse)));
  assign w_rt_hazard = w_rt_used && (w_rt != 5'd0) &&
                       (((r_e_dst == w_rt) && (r_e_tnew > w_rt_tuse)) ||
                        ((r_m_dst == w_rt) && (r_m_tnew > w_rt_tuse)));
  assign md_busy     = r_e_md || (r_md_cnt != 4'd0);
  assign w_md_hazard = w_md_op && md_busy;
  assign stall       = w_rs_hazard || w_rt_hazard || w_md_hazard;
  assign flush_idex  = stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_e_dst  <= 5'd0;
      r_e_tnew <= 2'd0;
      r_e_md   <= 1'b0;
      r_e_div  <= 1'b0;
      r_m_dst  <= 5'd0;
      r_m_tnew <= 2'd0;
      r_md_cnt <= 4'd0;
    end else begin
      r_m_dst  <= r_e_dst;
      r_m_tnew <= (r_e_tnew == 2'd0) ? 2'd0 : r_e_tnew - 2'd1;
      if (stall) begin
        r_e_dst  <= 5'd0;
        r_e_tnew <= 2'd0;
        r_e_md   <= 1'b0;
        r_e_div  <= 1'b0;
      end else begin
        r_e_dst  <= w_dst;
        r_e_tnew <= w_tnew;
        r_e_md   <= w_mult || w_div;
        r_e_div  <= w_div;
      end
      // The unit counts its busy window from the cycle the op leaves EX
      if (r_e_md) begin
        r_md_cnt <= r_e_div ? DivLoad : MultLoad;
      end else if (r_md_cnt != 4'd0) begin
        r_md_cnt <= r_md_cnt - 4'd1;
      end
    end
  end

endmodule
